// File: rtl/mini_alu_pkg.sv
// Shared definitions for the mini ALU stack core: opcodes, instruction
// field positions and the video pixel type.
package mini_alu_pkg;

   // Opcodes (instruction bits [4+3*FIELD_W-1 -: 4])
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_STO  = 4'h3;
   localparam logic [3:0] OP_INC  = 4'h4;
   localparam logic [3:0] OP_MOV  = 4'h5;
   localparam logic [3:0] OP_SMUL = 4'h6;
   localparam logic [3:0] OP_BLE  = 4'h7;
   localparam logic [3:0] OP_BGE  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_CALL = 4'hA;
   localparam logic [3:0] OP_RET  = 4'hB;
   localparam logic [3:0] OP_VGA  = 4'hC;

   // Instruction layout: {op[3:0], dest, src1, src0}, each field fw bits wide
   function automatic int op_lsb(input int fw);   return 3 * fw; endfunction
   function automatic int dest_lsb(input int fw); return 2 * fw; endfunction
   function automatic int src1_lsb(input int fw); return fw;     endfunction
   function automatic int src0_lsb(input int fw); return 0;      endfunction

   // One bit each of {R,G,B}
   typedef logic [2:0] vga_rgb_t;

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO. Pushes onto a full stack and pops from an empty one
// are dropped and latch a sticky fault that only reset clears.
module return_stack #(
   parameter int DEPTH = 8,
   parameter int W     = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [W-1:0]           i_data,
   output logic [W-1:0]           o_top,
   output logic [$clog2(DEPTH):0] o_depth,
   output logic                   o_full,
   output logic                   o_empty,
   output logic                   o_fault
);
   localparam int DW = $clog2(DEPTH) + 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [DW-1:0] r_depth;
   logic          r_fault;
   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_rd_idx;

   assign o_full   = (r_depth == DW'(DEPTH));
   assign o_empty  = (r_depth == '0);
   assign w_wr_idx = AW'(r_depth);
   assign w_rd_idx = AW'(r_depth - DW'(1));
   assign o_top    = r_mem[w_rd_idx];
   assign o_depth  = r_depth;
   assign o_fault  = r_fault;

   // Storage needs no reset: entries above the depth pointer are never read
   always_ff @(posedge i_clk) begin
      if (i_push && !o_full) r_mem[w_wr_idx] <= i_data;
   end

   // Occupancy and sticky fault; push wins if both are requested
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_depth <= '0;
         r_fault <= 1'b0;
      end else if (i_push) begin
         if (o_full) r_fault <= 1'b1;
         else        r_depth <= r_depth + DW'(1);
      end else if (i_pop) begin
         if (o_empty) r_fault <= 1'b1;
         else         r_depth <= r_depth - DW'(1);
      end
   end

endmodule

// File: rtl/mini_alu_stack_core.sv
// Single-issue mini ALU core: fetch from external ROM, execute from a latched
// decode register, hardware return stack, VGA write port.
// Optional feature: define MINI_ALU_SMUL_EN to build the signed multiplier;
// without it SMUL decodes as NOP.
module mini_alu_stack_core
   import mini_alu_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int IP_W        = 16,
   parameter int FIELD_W     = 8,
   parameter int REG_COUNT   = 16,
   parameter int STACK_DEPTH = 8,
   parameter int VGA_COL_W   = 7,
   parameter int VGA_ROW_W   = 6
) (
   input  logic                         Clock,
   input  logic                         Reset,
   output logic [IP_W-1:0]              oIP,
   input  logic [4+3*FIELD_W-1:0]       iInstruction,
   output logic                         oVGAWriteEnable,
   output logic [VGA_COL_W+VGA_ROW_W-1:0] oVGAWriteAddr,
   output vga_rgb_t                     oVGAWriteData,
   output logic [$clog2(STACK_DEPTH):0] oStackDepth,
   output logic                         oStackFault
);
   localparam int RA     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam int OP_L   = op_lsb(FIELD_W);
   localparam int DEST_L = dest_lsb(FIELD_W);
   localparam int SRC1_L = src1_lsb(FIELD_W);
   localparam int SRC0_L = src0_lsb(FIELD_W);

   // Decode register and fetch pointer; r_ip always holds execute-IP + 1
   logic [3:0]         r_op;
   logic [FIELD_W-1:0] r_dest, r_src1, r_src0;
   logic [IP_W-1:0]    r_ip;
   logic [DATA_W-1:0]  r_regs [REG_COUNT];

   logic [DATA_W-1:0]  w_a, w_b, w_wdata;
   logic               w_we, w_push, w_pop, w_taken, w_full, w_empty;
   logic [IP_W-1:0]    w_target, w_top;

   assign w_a = r_regs[r_src1[RA-1:0]];
   assign w_b = r_regs[r_src0[RA-1:0]];

`ifdef MINI_ALU_SMUL_EN
   // Low half of a two's-complement product is the same signed or unsigned
   logic signed [DATA_W-1:0] w_prod;
   assign w_prod = $signed(w_a) * $signed(w_b);
`endif

   // Execute: ALU result, write enable, branch decision and stack requests
   always_comb begin
      w_we     = 1'b0;
      w_wdata  = '0;
      w_taken  = 1'b0;
      w_target = IP_W'(r_dest);
      w_push   = 1'b0;
      w_pop    = 1'b0;
      case (r_op)
         OP_ADD:  begin w_we = 1'b1; w_wdata = w_a + w_b; end
         OP_SUB:  begin w_we = 1'b1; w_wdata = w_a - w_b; end
         OP_STO:  begin w_we = 1'b1; w_wdata = DATA_W'({r_src1, r_src0}); end
         OP_INC:  begin w_we = 1'b1; w_wdata = w_a + DATA_W'(1); end
         OP_MOV:  begin w_we = 1'b1; w_wdata = w_a; end
`ifdef MINI_ALU_SMUL_EN
         OP_SMUL: begin w_we = 1'b1; w_wdata = w_prod; end
`endif
         OP_BLE:  w_taken = ($signed(w_a) <= $signed(w_b));
         OP_BGE:  w_taken = ($signed(w_a) >= $signed(w_b));
         OP_JMP:  w_taken = 1'b1;
         // A full stack turns CALL into a NOP (the stack records the fault)
         OP_CALL: begin w_push = 1'b1; w_taken = !w_full; end
         OP_RET:  begin w_pop = 1'b1; w_taken = !w_empty; w_target = w_top; end
         default: ;
      endcase
   end

   // Taken branches redirect the fetch address in the same cycle: no bubble
   assign oIP = w_taken ? w_target : r_ip;

   // Fetch/decode pipeline register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_ip   <= '0;
         r_op   <= OP_NOP;
         r_dest <= '0;
         r_src1 <= '0;
         r_src0 <= '0;
      end else begin
         r_ip   <= oIP + IP_W'(1);
         r_op   <= iInstruction[OP_L +: 4];
         r_dest <= iInstruction[DEST_L +: FIELD_W];
         r_src1 <= iInstruction[SRC1_L +: FIELD_W];
         r_src0 <= iInstruction[SRC0_L +: FIELD_W];
      end
   end

   // Register file write-back at the end of the execute cycle
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      end else if (w_we) begin
         r_regs[r_dest[RA-1:0]] <= w_wdata;
      end
   end

   // Video port is live only during a VGA execute cycle, zero otherwise
   assign oVGAWriteEnable = (r_op == OP_VGA);
   assign oVGAWriteAddr   = oVGAWriteEnable ? {w_a[VGA_COL_W-1:0], w_b[VGA_ROW_W-1:0]} : '0;
   assign oVGAWriteData   = oVGAWriteEnable ? vga_rgb_t'(r_dest[2:0]) : '0;

   return_stack #(.DEPTH(STACK_DEPTH), .W(IP_W)) u_stack (
      .i_clk   (Clock),
      .i_rst   (Reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (r_ip),
      .o_top   (w_top),
      .o_depth (oStackDepth),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_fault (oStackFault)
   );

endmodule

// File: doc/mini_alu_stack_core.md
# mini_alu_stack_core

Parametrised successor to the MiniAlu datapath: a single-issue core that fetches 28-bit-class instructions from an external instruction ROM and executes them against an internal register file. It replaces the single-entry CALL/RET buffer with a configurable hardware return-address stack that detects overflow and underflow. It also drives a video-memory write port for the VGA frame buffer. It sits between the instruction ROM and the VGA RAM in the top level, clocked on `Clock`.

## Interface
- `DATA_W`, 16, register and ALU width
- `IP_W`, 16, instruction pointer width
- `FIELD_W`, 8, width of each instruction field (dest, src1, src0); instruction width = 4 + 3·FIELD_W
- `REG_COUNT`, 16, number of registers; fields index with low log2(REG_COUNT) bits
- `STACK_DEPTH`, 8, return-address stack entries (≥1)
- `VGA_COL_W`, 7, video column address width
- `VGA_ROW_W`, 6, video row address width

Ports:
- `Clock` in 1: sole clock; all state on rising edge
- `Reset` in 1: asynchronous, active-high
- `oIP` out IP_W: instruction ROM address (combinational)
- `iInstruction` in 4+3·FIELD_W: ROM data, combinational read of `oIP`
- `oVGAWriteEnable` out 1: video RAM write strobe
- `oVGAWriteAddr` out VGA_COL_W+VGA_ROW_W: {column, row}
- `oVGAWriteData` out 3: {R,G,B}
- `oStackDepth` out log2(STACK_DEPTH)+1: current stack occupancy
- `oStackFault` out 1: sticky overflow/underflow flag

## Operation
- Two-phase flow: fetch presents `oIP`; next edge latches {op, dest, src1, src0} into the decode register and advances the IP counter; the execute cycle then acts on the latched fields.
- Register reads are combinational from the latched src fields. Writes occur at the end of the execute cycle, so the next instruction sees the new value (no hazard).
- Ops, 4-bit codes in package:
  - NOP
  - ADD/SUB: dest←src1±src0, mod 2^DATA_W
  - STO: dest←{src1,src0} truncated/zero-extended to DATA_W
  - INC: dest←src1+1
  - MOV: dest←src1
  - SMUL: dest←low DATA_W bits of signed src1·src0
  - BLE/BGE: signed compare of R[src1] vs R[src0]; branch to dest field if true
  - JMP
  - CALL
  - RET
  - VGA: col←R[src1][VGA_COL_W-1:0], row←R[src0][VGA_ROW_W-1:0], data←dest[2:0]
- Branch target: dest field zero-extended to IP_W.
- Taken branch: `oIP` switches combinationally to the target in the execute cycle. No delay slot, zero bubble.
- CALL pushes execute-IP+1, i.e. the address after the CALL, then jumps.
- RET pops and jumps to the popped address.
- CALL when depth=STACK_DEPTH: no push, no jump (behaves as NOP); sets `oStackFault`.
- RET when depth=0: no jump; sets `oStackFault`.
- `oStackFault` is cleared only by `Reset`.
- Undefined opcodes behave as NOP.
- IP wraps modulo 2^IP_W.

## Timing
- On `Reset` assertion, asynchronously:
  - IP=0
  - decode register=NOP
  - all registers=0
  - stack depth=0
  - `oStackFault`=0
  - `oVGAWriteEnable`=0
- Outputs during reset: `oIP`=0, `oVGAWriteAddr`/`oVGAWriteData`=0.
- The first edge after release latches instruction 0; it executes in the following cycle.
- Throughput is one instruction per cycle, including taken branches.
- `oVGAWriteEnable` is high for exactly the VGA execute cycle; address and data are valid in that same cycle.
- `oStackDepth` updates on the edge ending a CALL/RET execute cycle.
- Back-to-back CALL/RET are legal; RET immediately after CALL returns to CALL+1.
- `Reset` mid-instruction aborts it: no register write, no push.

## Configuration
- Macro: `MINI_ALU_SMUL_EN`.
  - Defined: multiplier instantiated; SMUL behaves as above.
  - Undefined: no multiplier logic; SMUL decodes as NOP (no write, no fault).

## Structure
- Shared package `mini_alu_pkg` holds:
  - opcode constants
  - instruction field slice positions
  - the `vga_rgb_t` 3-bit type
- One natural sub-module: `return_stack`, an LIFO of STACK_DEPTH×IP_W with push/pop, full/empty, depth output and sticky fault.
- The register file stays inline.

## Test plan
- Reset then STO R1,0x0005; STO R2,0x0003; ADD R3,R1,R2; SUB R4,R1,R2 → R3=8, R4=2; `oIP` increments 0,1,2,3 one per cycle.
- STO R1,0xFFFF (−1); STO R2,1; BLE to 0x20 (R1≤R2) → next `oIP`=0x20 in the execute cycle. BGE with the same operands → not taken.
- CALL 0x10 at address 4; RET at 0x10 → `oIP` sequence 4,0x10,5; `oStackDepth` 0→1→0.
- STACK_DEPTH=2: three nested CALLs → third does not jump, `oStackFault`=1, depth stays 2. Separately, RET at depth 0 → fault, IP falls through.
- STO R1,10; STO R2,20; VGA dest=3'b101 → single-cycle `oVGAWriteEnable`, `oVGAWriteAddr`={7'd10,6'd20}, data 3'b101.
- STO R1,0x0100; STO R2,0x0003; SMUL R3,R1,R2 → R3=0x0300 with `MINI_ALU_SMUL_EN` defined; R3 unchanged (0) without it.
